// File: rtl/econet_rx_framer_if.sv
// Econet receive framer bus: receiver strobes into the framer plus the
// CPU-side byte read port. The master drives receive strobes and rd_en;
// the slave (framer) returns the popped byte and the empty flag.
interface econet_rx_framer_if;
    logic [7:0] rx_byte;
    logic       rx_byte_ready;
    logic       rx_frame_start;
    logic       rx_frame_end;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_empty;

    modport master (
        output rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rd_en,
        input  rd_data, rd_last, rd_empty
    );

    modport slave (
        input  rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rd_en,
        output rd_data, rd_last, rd_empty
    );
endinterface

// File: rtl/econet_rx_framer.sv
// Buffered Econet receive framer: CRC-16/X-25 check, destination filter,
// runt/overflow/FCS drop by write-pointer rollback, byte FIFO with last flag.
// Optional statistics counters are built only when ECONET_RX_STATS_EN is defined.
//
// state      | meaning
// ST_IDLE    | between frames, waiting for an opening flag
// ST_HDR     | frame open, waiting for the destination byte
// ST_RECV    | accepted frame, bytes flow through the 3-byte delay line
// ST_DISCARD | frame rejected or overflowed, ignore until next flag
module econet_rx_framer #(
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int MIN_LEN = 4
) (
    input  logic                      econet_clk,
    input  logic                      reset,
    econet_rx_framer_if.slave         bus,
    input  logic [7:0]                station,
    input  logic                      promisc,
    output logic [7:0]                frames_pending,
    output logic                      err_fcs,
    output logic                      err_overflow,
    output logic                      err_runt,
    output logic [15:0]               stat_good,
    output logic [15:0]               stat_fcs,
    output logic [15:0]               stat_ovf
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_HDR     = 2'd1;
    localparam logic [1:0]  ST_RECV    = 2'd2;
    localparam logic [1:0]  ST_DISCARD = 2'd3;
    localparam logic [AW:0] FULL_DIFF  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
    localparam logic [7:0]  RUNT_LIM   = 8'(MIN_LEN + 2);

    logic [8:0]  mem [DEPTH];
    logic [1:0]  state, state_n;
    logic [15:0] crc, crc_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  held, held_n;
    logic [7:0]  d0, d1, d2, d0_n, d1_n, d2_n;
    logic [AW:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr;
    logic        we_a, we_b;
    logic [AW:0] wa_a, wa_b;
    logic [8:0]  wd_a, wd_b;
    logic        runt_n, fcs_n, ovf_n, commit;
    logic        rd_empty_i, pop, pop_last;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w - r) == FULL_DIFF;
    endfunction

    // Frame processing: start first, then the byte, then the end check.
    always_comb begin
        state_n     = state;
        crc_n       = crc;
        cnt_n       = cnt;
        held_n      = held;
        d0_n        = d0;
        d1_n        = d1;
        d2_n        = d2;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        runt_n = 1'b0; fcs_n = 1'b0; ovf_n = 1'b0; commit = 1'b0;

        if (bus.rx_frame_start) begin
            if (state == ST_HDR || state == ST_RECV)
                runt_n = 1'b1;
            state_n  = ST_HDR;
            crc_n    = 16'hFFFF;
            cnt_n    = '0;
            held_n   = '0;
            wr_ptr_n = wr_commit;
        end

        if (bus.rx_byte_ready && (state_n == ST_HDR || state_n == ST_RECV)) begin
            crc_n = crc_step(crc_n, bus.rx_byte);
            if (cnt_n != 8'hFF)
                cnt_n = cnt_n + 8'd1;
            if (state_n == ST_HDR) begin
                if (bus.rx_byte == station || bus.rx_byte == 8'hFF || promisc)
                    state_n = ST_RECV;
                else
                    state_n = ST_DISCARD;
            end else if (held_n == 2'd3) begin
                if (ptr_full(wr_ptr_n, rd_ptr)) begin
                    ovf_n    = 1'b1;
                    wr_ptr_n = wr_commit;
                    state_n  = ST_DISCARD;
                end else begin
                    we_a     = 1'b1;
                    wa_a     = wr_ptr_n;
                    wd_a     = {1'b0, d2_n};
                    wr_ptr_n = wr_ptr_n + PTR_ONE;
                end
            end
            d2_n = d1_n;
            d1_n = d0_n;
            d0_n = bus.rx_byte;
            if (held_n != 2'd3)
                held_n = held_n + 2'd1;
        end

        if (bus.rx_frame_end && !bus.rx_frame_start) begin
            if (state_n == ST_HDR) begin
                runt_n   = 1'b1;
                wr_ptr_n = wr_commit;
            end else if (state_n == ST_RECV) begin
                if (held_n != 2'd3 || cnt_n < RUNT_LIM) begin
                    runt_n   = 1'b1;
                    wr_ptr_n = wr_commit;
                end else if (crc_n != 16'hF0B8) begin
                    fcs_n    = 1'b1;
                    wr_ptr_n = wr_commit;
                end else if (ptr_full(wr_ptr_n, rd_ptr)) begin
                    ovf_n    = 1'b1;
                    wr_ptr_n = wr_commit;
                end else begin
                    we_b        = 1'b1;
                    wa_b        = wr_ptr_n;
                    wd_b        = {1'b1, d2_n};
                    commit      = 1'b1;
                    wr_ptr_n    = wr_ptr_n + PTR_ONE;
                    wr_commit_n = wr_ptr_n;
                end
            end
            state_n = ST_IDLE;
        end
    end

    // Write-side state and error pulses.
    always_ff @(posedge econet_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            crc          <= 16'hFFFF;
            cnt          <= '0;
            held         <= '0;
            d0           <= '0;
            d1           <= '0;
            d2           <= '0;
            wr_ptr       <= '0;
            wr_commit    <= '0;
            err_runt     <= 1'b0;
            err_fcs      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            crc          <= crc_n;
            cnt          <= cnt_n;
            held         <= held_n;
            d0           <= d0_n;
            d1           <= d1_n;
            d2           <= d2_n;
            wr_ptr       <= wr_ptr_n;
            wr_commit    <= wr_commit_n;
            err_runt     <= runt_n;
            err_fcs      <= fcs_n;
            err_overflow <= ovf_n;
        end
    end

    // FIFO storage; a byte and a closing flag together need two writes.
    always_ff @(posedge econet_clk) begin
        if (we_a)
            mem[wa_a[AW-1:0]] <= wd_a;
        if (we_b)
            mem[wa_b[AW-1:0]] <= wd_b;
    end

    assign rd_empty_i   = (rd_ptr == wr_commit);
    assign pop          = bus.rd_en && !rd_empty_i;
    assign pop_last     = pop && mem[rd_ptr[AW-1:0]][8];
    assign bus.rd_empty = rd_empty_i;

    // Read port: registered pop of committed bytes.
    always_ff @(posedge econet_clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            bus.rd_data <= '0;
            bus.rd_last <= 1'b0;
        end else if (pop) begin
            {bus.rd_last, bus.rd_data} <= mem[rd_ptr[AW-1:0]];
            rd_ptr                     <= rd_ptr + PTR_ONE;
        end
    end

    // Committed-frame count; commit and last-pop together cancel.
    always_ff @(posedge econet_clk) begin
        if (reset)
            frames_pending <= '0;
        else if (commit && !pop_last && frames_pending != 8'hFF)
            frames_pending <= frames_pending + 8'd1;
        else if (pop_last && !commit && frames_pending != 8'h00)
            frames_pending <= frames_pending - 8'd1;
    end

`ifdef ECONET_RX_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge econet_clk) begin
        if (reset) begin
            stat_good <= '0;
            stat_fcs  <= '0;
            stat_ovf  <= '0;
        end else begin
            if (commit && stat_good != 16'hFFFF)
                stat_good <= stat_good + 16'd1;
            if (fcs_n && stat_fcs != 16'hFFFF)
                stat_fcs <= stat_fcs + 16'd1;
            if (ovf_n && stat_ovf != 16'hFFFF)
                stat_ovf <= stat_ovf + 16'd1;
        end
    end
`else
    assign stat_good = '0;
    assign stat_fcs  = '0;
    assign stat_ovf  = '0;
`endif
endmodule

// File: tb/tb_econet_rx_framer.sv
// Testbench for econet_rx_framer: directed scenarios plus random frames
// checked against a queue-based model of committed FIFO contents.
module tb_econet_rx_framer;
    localparam int DEPTH   = 16;
    localparam int MIN_LEN = 4;

    logic        econet_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [7:0]  station    = 8'h31;
    logic        promisc    = 1'b0;
    logic [7:0]  frames_pending;
    logic        err_fcs, err_overflow, err_runt;
    logic [15:0] stat_good, stat_fcs, stat_ovf;

    econet_rx_framer_if bus();

    econet_rx_framer #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN)) dut (
        .econet_clk     (econet_clk),
        .reset          (reset),
        .bus            (bus),
        .station        (station),
        .promisc        (promisc),
        .frames_pending (frames_pending),
        .err_fcs        (err_fcs),
        .err_overflow   (err_overflow),
        .err_runt       (err_runt),
        .stat_good      (stat_good),
        .stat_fcs       (stat_fcs),
        .stat_ovf       (stat_ovf)
    );

    always #5 econet_clk = ~econet_clk;

    int checks = 0;
    int errors = 0;
    int n_fcs = 0, n_ovf = 0, n_runt = 0;

    logic [8:0] exp_q[$];
    int         exp_pending = 0;
    logic [7:0] fr[$];

    always @(negedge econet_clk) begin
        if (err_fcs)      n_fcs++;
        if (err_overflow) n_ovf++;
        if (err_runt)     n_runt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_bytes(input int upto);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < upto; i++) begin
            c = c ^ {8'h00, fr[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input logic [7:0] dest, input int n, input bit good);
        logic [15:0] fcs;
        fr.delete();
        fr.push_back(dest);
        for (int i = 1; i < n; i++)
            fr.push_back(8'($urandom));
        fcs = ~crc_bytes(n);
        fr.push_back(good ? fcs[7:0] : (fcs[7:0] ^ 8'(1 + $urandom_range(0, 254))));
        fr.push_back(fcs[15:8]);
    endtask

    task automatic drive(input bit s, input bit r, input logic [7:0] b, input bit e);
        @(negedge econet_clk);
        bus.rx_frame_start = s;
        bus.rx_byte_ready  = r;
        bus.rx_byte        = b;
        bus.rx_frame_end   = e;
    endtask

    // Sends fr, predicts the outcome from the frame rules, checks pulses and state.
    task automatic send_frame(input int pre_runt, input bit pop_at_end);
        int total = fr.size();
        int free_sp = DEPTH - exp_q.size();
        int e_r = pre_runt, e_f = 0, e_o = 0;
        int b_r = n_runt, b_f = n_fcs, b_o = n_ovf;
        bit acc, com = 1'b0, swb, ewl;
        logic [8:0] popped = '0;
        acc = (fr[0] == station) || (fr[0] == 8'hFF) || promisc;
        if (acc) begin
            if (total - 3 > free_sp)                 e_o = 1;
            else if (total < MIN_LEN + 2)            e_r++;
            else if (crc_bytes(total) != 16'hF0B8)   e_f = 1;
            else if (total - 2 > free_sp)            e_o = 1;
            else                                     com = 1'b1;
        end
        swb = 1'($urandom);
        ewl = pop_at_end || (1'($urandom) && !(swb && total == 1));
        if (!swb) drive(1, 0, 8'h00, 0);
        for (int i = 0; i < total; i++) begin
            drive(i == 0 && swb, 1, fr[i], i == total - 1 && ewl);
            if (i != total - 1 && $urandom_range(0, 3) == 0) drive(0, 0, 8'h00, 0);
        end
        if (!ewl) drive(0, 0, 8'h00, 1);
        if (pop_at_end) begin
            bus.rd_en = 1'b1;
            popped = exp_q.pop_front();
            if (popped[8]) exp_pending--;
        end
        drive(0, 0, 8'h00, 0);
        bus.rd_en = 1'b0;
        if (pop_at_end)
            check("pop_entry", {23'd0, bus.rd_last, bus.rd_data}, {23'd0, popped});
        drive(0, 0, 8'h00, 0);
        if (com) begin
            for (int i = 0; i < total - 2; i++)
                exp_q.push_back({i == total - 3, fr[i]});
            exp_pending++;
        end
        check("err_runt_cnt", n_runt - b_r, e_r);
        check("err_fcs_cnt", n_fcs - b_f, e_f);
        check("err_ovf_cnt", n_ovf - b_o, e_o);
        check("frames_pending", frames_pending, exp_pending);
        check("rd_empty", bus.rd_empty, exp_q.size() == 0);
    endtask

    task automatic pop_one();
        logic [8:0] e;
        if (exp_q.size() == 0) return;
        @(negedge econet_clk);
        bus.rd_en = 1'b1;
        @(negedge econet_clk);
        bus.rd_en = 1'b0;
        e = exp_q.pop_front();
        if (e[8]) exp_pending--;
        check("rd_entry", {23'd0, bus.rd_last, bus.rd_data}, {23'd0, e});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) pop_one();
        check("pending_after_read", frames_pending, exp_pending);
        check("empty_after_read", bus.rd_empty, exp_q.size() == 0);
    endtask

    initial begin
        logic [7:0] dst;
        bus.rx_byte = '0; bus.rx_byte_ready = 0; bus.rx_frame_start = 0;
        bus.rx_frame_end = 0; bus.rd_en = 0;
        repeat (3) @(negedge econet_clk);
        reset = 1'b0;
        check("reset_empty", bus.rd_empty, 1);
        check("reset_pending", frames_pending, 0);
        check("reset_rd", {bus.rd_last, bus.rd_data}, 0);
        check("reset_pulses", n_fcs + n_ovf + n_runt, 0);

        // Known X-25 check vector, good then with corrupted FCS.
        fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        send_frame(0, 0);
        drain(exp_q.size());
        fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6F, 8'h90};
        send_frame(0, 0);
`ifdef ECONET_RX_STATS_EN
        check("stat_good", stat_good, 1);
        check("stat_fcs", stat_fcs, 1);
        check("stat_ovf", stat_ovf, 0);
`else
        check("stat_zero", {stat_good, stat_fcs | stat_ovf}, 0);
`endif

        // Destination filter, then broadcast.
        station = 8'h05;
        build_frame(8'h31, 6, 1); send_frame(0, 0);
        build_frame(8'hFF, 6, 1); send_frame(0, 0);
        drain(exp_q.size());

        // Overflow with a small FIFO, then recovery.
        build_frame(8'h05, 12, 1); send_frame(0, 0);
        build_frame(8'h05, 12, 1); send_frame(0, 0);
        drain(exp_q.size());
        build_frame(8'h05, 12, 1); send_frame(0, 0);
        drain(exp_q.size());

        // Runt, then abort mid-frame followed by a good frame.
        build_frame(8'h05, 3, 1); send_frame(0, 0);
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h05, 0);
        drive(0, 1, 8'hA1, 0);
        drive(0, 1, 8'hA2, 0);
        build_frame(8'h05, 7, 1); send_frame(1, 0);
        drain(exp_q.size());

        // Last-byte pop of frame A coincides with commit of frame B.
        build_frame(8'h05, 5, 1); send_frame(0, 0);
        drain(4);
        check("pending_before_coinc", frames_pending, 1);
        build_frame(8'h05, 6, 1); send_frame(0, 1);
        drain(exp_q.size());

        // Random frames against the model.
        for (int f = 0; f < 150; f++) begin
            if (f % 40 == 0) station = 8'($urandom);
            promisc = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0: dst = station;
                1: dst = 8'hFF;
                default: dst = 8'($urandom);
            endcase
            build_frame(dst, $urandom_range(1, 13), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                while (fr.size() > $urandom_range(1, 2)) void'(fr.pop_back());
            send_frame(0, 0);
            if ($urandom_range(0, 2) == 0)
                drain($urandom_range(0, exp_q.size()));
        end
        drain(exp_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
